// File: rtl/pe_driver_pkg.sv
// Shared default sizing for the PE driver and its FIFOs.
package pe_driver_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_INST_WIDTH = 32;
  localparam int unsigned DEF_INST_NUM   = 16;
  localparam int unsigned DEF_LOAD_NUM   = 16;
  localparam int unsigned DEF_TX_NUM     = 4;
  localparam int unsigned DEF_ITER_NUM   = 8;
  localparam int unsigned DEF_ALPHA_NUM  = 8;
  localparam int unsigned DEF_TIMEOUT    = 1023;

endpackage

// File: rtl/pe_driver_sync.sv
// Synchronous FIFO with occupancy count; simultaneous push/pop is legal at any
// occupancy, and on an empty FIFO the pushed word passes straight through.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign bypass  = empty && push && pop;
  assign do_push = push && !bypass && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rd_data = bypass ? wr_data : (empty ? '0 : mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_driver.sv
// Host-to-PE driver: streams a program and per-iteration data bursts into the
// PE, then collects the PE results into an output stream.
module pe_driver
  import pe_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
  parameter int unsigned INST_NUM   = DEF_INST_NUM,
  parameter int unsigned LOAD_NUM   = DEF_LOAD_NUM,
  parameter int unsigned TX_NUM     = DEF_TX_NUM,
  parameter int unsigned ITER_NUM   = DEF_ITER_NUM,
  parameter int unsigned ALPHA_NUM  = DEF_ALPHA_NUM,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    inst_s_valid,
  output logic                    inst_s_ready,
  input  logic [INST_WIDTH-1:0]   inst_s_data,
  input  logic                    data_s_valid,
  output logic                    data_s_ready,
  input  logic [2*DATA_WIDTH-1:0] data_s_data,
  output logic                    inst_in_v,
  output logic [INST_WIDTH-1:0]   inst_in,
  output logic                    din_pe_v,
  output logic [2*DATA_WIDTH-1:0] din_pe,
  input  logic                    dout_pe_v,
  input  logic [2*DATA_WIDTH-1:0] dout_pe,
  output logic                    res_m_valid,
  input  logic                    res_m_ready,
  output logic [2*DATA_WIDTH-1:0] res_m_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned DW       = 2 * DATA_WIDTH;
  localparam int unsigned WAIT_CYC = INST_NUM + TX_NUM;
  localparam int unsigned ICW      = $clog2(INST_NUM + 1);
  localparam int unsigned LCW      = $clog2(LOAD_NUM + 1);
  localparam int unsigned WCW      = $clog2(WAIT_CYC + 1);
  localparam int unsigned ITW      = $clog2(ITER_NUM + 1);
  localparam int unsigned RCW      = $clog2(ALPHA_NUM + 1);
  localparam int unsigned TCW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, INST, FILL, LOAD, WAIT, COLLECT, DRAIN
  } state_t;

  state_t          state;
  logic [ICW-1:0]  inst_cnt;
  logic [LCW-1:0]  load_cnt;
  logic [WCW-1:0]  wait_cnt;
  logic [ITW-1:0]  iter_cnt;
  logic [RCW-1:0]  res_cnt;
  logic [TCW-1:0]  idle_cnt;

  logic [LCW-1:0]  data_count;
  logic [DW-1:0]   data_rd;
  logic            data_full;
  logic            data_push;
  logic            data_pop;
  logic            data_flush;
  logic [RCW-1:0]  res_count;
  logic            res_empty;
  logic            res_push;
  logic            res_pop;
  logic            res_flush;
  logic            wait_last;
  logic            underrun;
  logic            timeout_hit;

  // FIFO handshakes and abort conditions
  assign data_full    = (data_count == LCW'(LOAD_NUM));
  assign data_s_ready = !data_full;
  assign data_push    = data_s_valid && !data_full;
  assign data_pop     = (state == LOAD);
  assign res_empty    = (res_count == '0);
  assign res_m_valid  = !res_empty;
  assign res_push     = (state == COLLECT) && dout_pe_v;
  assign res_pop      = res_m_valid && res_m_ready;
  assign wait_last    = (state == WAIT) && (wait_cnt == WCW'(WAIT_CYC - 1));
  assign underrun     = wait_last && (data_count < LCW'(LOAD_NUM));
  assign timeout_hit  = (state == COLLECT) && !dout_pe_v && (idle_cnt == TCW'(TIMEOUT - 1));
  assign data_flush   = underrun || timeout_hit;
  assign res_flush    = timeout_hit;

  sync_fifo #(.WIDTH(DW), .DEPTH(LOAD_NUM)) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (data_flush),
    .push    (data_push),
    .wr_data (data_s_data),
    .pop     (data_pop),
    .rd_data (data_rd),
    .count   (data_count)
  );

  sync_fifo #(.WIDTH(DW), .DEPTH(ALPHA_NUM)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (res_flush),
    .push    (res_push),
    .wr_data (dout_pe),
    .pop     (res_pop),
    .rd_data (res_m_data),
    .count   (res_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      inst_cnt     <= '0;
      load_cnt     <= '0;
      wait_cnt     <= '0;
      iter_cnt     <= '0;
      res_cnt      <= '0;
      idle_cnt     <= '0;
      inst_s_ready <= 1'b0;
      inst_in_v    <= 1'b0;
      inst_in      <= '0;
      din_pe_v     <= 1'b0;
      din_pe       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      inst_in_v <= 1'b0;
      din_pe_v  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= INST;
            inst_s_ready <= 1'b1;
            busy         <= 1'b1;
            err          <= 1'b0;
            iter_cnt     <= '0;
            inst_cnt     <= '0;
            idle_cnt     <= '0;
          end
        end
        INST: begin
          if (inst_s_valid) begin
            inst_in   <= inst_s_data;
            inst_in_v <= 1'b1;
            inst_cnt  <= inst_cnt + ICW'(1);
            if (inst_cnt == ICW'(INST_NUM - 1)) begin
              state        <= FILL;
              inst_s_ready <= 1'b0;
            end
          end
        end
        FILL: begin
          if (data_full) begin
            state    <= LOAD;
            load_cnt <= '0;
          end
        end
        LOAD: begin
          din_pe   <= data_rd;
          din_pe_v <= 1'b1;
          load_cnt <= load_cnt + LCW'(1);
          if (load_cnt == LCW'(LOAD_NUM - 1)) begin
            if (iter_cnt < ITW'(ITER_NUM - 1)) begin
              state    <= WAIT;
              wait_cnt <= '0;
            end else begin
              state    <= COLLECT;
              idle_cnt <= '0;
              res_cnt  <= '0;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WCW'(1);
          if (underrun) begin
            state <= IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else if (wait_last) begin
            state    <= LOAD;
            load_cnt <= '0;
            iter_cnt <= iter_cnt + ITW'(1);
          end
        end
        COLLECT: begin
          if (dout_pe_v) begin
            idle_cnt <= '0;
            res_cnt  <= res_cnt + RCW'(1);
            if (res_cnt == RCW'(ALPHA_NUM - 1)) state <= DRAIN;
          end else if (timeout_hit) begin
            state <= IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + TCW'(1);
          end
        end
        DRAIN: begin
          // Results may still be draining; finish only once the stream is empty
          if (res_empty) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_driver.sv
// Directed bench for pe_driver: scenario table plus a mid-run reset sequence.
module tb_pe_driver;

  typedef struct {
    int data_limit;
    int pe_words;
    bit ready_block;
    bit exp_err;
    int exp_done;
    int exp_results;
    int exp_bursts;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        inst_s_valid;
  logic        inst_s_ready;
  logic [31:0] inst_s_data;
  logic        data_s_valid;
  logic        data_s_ready;
  logic [31:0] data_s_data;
  logic        inst_in_v;
  logic [31:0] inst_in;
  logic        din_pe_v;
  logic [31:0] din_pe;
  logic        dout_pe_v;
  logic [31:0] dout_pe;
  logic        res_m_valid;
  logic        res_m_ready;
  logic [31:0] res_m_data;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  pe_driver dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .inst_s_valid (inst_s_valid),
    .inst_s_ready (inst_s_ready),
    .inst_s_data  (inst_s_data),
    .data_s_valid (data_s_valid),
    .data_s_ready (data_s_ready),
    .data_s_data  (data_s_data),
    .inst_in_v    (inst_in_v),
    .inst_in      (inst_in),
    .din_pe_v     (din_pe_v),
    .din_pe       (din_pe),
    .dout_pe_v    (dout_pe_v),
    .dout_pe      (dout_pe),
    .res_m_valid  (res_m_valid),
    .res_m_ready  (res_m_ready),
    .res_m_data   (res_m_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int inst_sent, data_sent, data_limit, din_total, bursts, run_len, gap_len;
  int done_cnt, done_cyc, err_cyc, last_pop_cyc, pe_emit, pe_words, pe_timer;
  int last_pe_cyc, rel_cnt;
  bit inst_en, data_en, junk_sent, ready_block;
  logic prev_din_v, prev_err;
  logic [31:0] rx_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_bench();
    inst_sent = 0; data_sent = 0; data_limit = 0; din_total = 0; bursts = 0;
    run_len = 0; gap_len = 0; done_cnt = 0; done_cyc = -1; err_cyc = -1;
    last_pop_cyc = -1; pe_emit = 0; pe_words = 0; pe_timer = 0; last_pe_cyc = -1;
    rel_cnt = 0; inst_en = 0; data_en = 0; junk_sent = 0; ready_block = 0;
    prev_din_v = 1'b0; prev_err = 1'b0; rx_q.delete();
    start = 1'b0; inst_s_valid = 1'b0; inst_s_data = '0; data_s_valid = 1'b0;
    data_s_data = '0; dout_pe_v = 1'b0; dout_pe = '0; res_m_ready = 1'b0;
  endtask

  // One clock: capture handshakes, advance, check monitors, drive next inputs
  task automatic step();
    logic d_acc, i_acc, r_acc;
    logic [31:0] i_word, r_word;
    d_acc  = data_s_valid && data_s_ready;
    i_acc  = inst_s_valid && inst_s_ready;
    i_word = inst_s_data;
    r_acc  = res_m_valid && res_m_ready;
    r_word = res_m_data;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) return;
    if (d_acc) data_sent++;
    if (i_acc) inst_sent++;
    if (r_acc) begin
      rx_q.push_back(r_word);
      last_pop_cyc = cyc;
    end
    if (i_acc || inst_in_v) begin
      check("inst_in_v", 64'(inst_in_v), 64'(i_acc));
      if (i_acc) check("inst_in", 64'(inst_in), 64'(i_word));
    end
    if (din_pe_v) begin
      check("din_pe", 64'(din_pe), 64'(32'h0001_0000 + 32'(din_total)));
      din_total++;
      if (!prev_din_v) begin
        if (bursts > 0) check("load_gap", 64'(gap_len), 64'd20);
        bursts++;
        run_len = 0;
      end
      run_len++;
      gap_len = 0;
    end else begin
      if (prev_din_v) check("burst_len", 64'(run_len), 64'd16);
      gap_len++;
    end
    prev_din_v = din_pe_v;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err && !prev_err) err_cyc = cyc;
    prev_err = err;

    inst_s_valid = inst_en && (inst_sent < 16);
    inst_s_data  = 32'(inst_sent + 1);
    data_s_valid = data_en && (data_sent < data_limit);
    data_s_data  = 32'h0001_0000 + 32'(data_sent);
    dout_pe_v = 1'b0;
    dout_pe   = '0;
    if (!junk_sent && din_total == 16 && !din_pe_v) begin
      dout_pe_v = 1'b1;
      dout_pe   = 32'hDEAD_BEEF;
      junk_sent = 1;
    end
    if (din_total == 128 && pe_emit < pe_words) begin
      pe_timer++;
      if (pe_timer % 3 == 0) begin
        dout_pe_v   = 1'b1;
        dout_pe     = 32'h0000_00A0 + 32'(pe_emit);
        pe_emit++;
        last_pe_cyc = cyc + 1;
      end
    end
    if (ready_block && pe_words > 0 && pe_emit == pe_words) rel_cnt++;
    res_m_ready = !ready_block || (rel_cnt > 5);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({inst_s_ready, inst_in_v, din_pe_v, res_m_valid, busy, done, err}), 64'd0);
    check({tag, "_inst_in"}, 64'(inst_in), 64'd0);
    check({tag, "_din_pe"}, 64'(din_pe), 64'd0);
    check({tag, "_res_data"}, 64'(res_m_data), 64'd0);
    check({tag, "_data_ready"}, 64'(data_s_ready), 64'd1);
  endtask

  task automatic do_reset();
    clear_bench();
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
  endtask

  task automatic run_scenario(input vec_t v, input bit with_reset);
    int guard;
    if (with_reset) do_reset();
    data_limit  = v.data_limit;
    pe_words    = v.pe_words;
    ready_block = v.ready_block;
    inst_en = 1;
    data_en = 1;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    guard = 0;
    while (busy && guard < 4000) begin
      step();
      guard++;
    end
    check("run_budget_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) step();
    check("err", 64'(err), 64'(v.exp_err));
    check("done_cnt", 64'(done_cnt), 64'(v.exp_done));
    check("bursts", 64'(bursts), 64'(v.exp_bursts));
    check("inst_count", 64'(inst_sent), 64'd16);
    check("res_count", 64'(rx_q.size()), 64'(v.exp_results));
    for (int k = 0; k < rx_q.size() && k < v.exp_results; k++)
      check("res_data", 64'(rx_q[k]), 64'(32'h0000_00A0 + 32'(k)));
    check("res_valid_end", 64'(res_m_valid), 64'd0);
    if (v.exp_done > 0) check("done_after_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
    if (v.exp_err && v.pe_words > 0) check("timeout_cycles", 64'(err_cyc - last_pe_cyc), 64'd1023);
  endtask

  vec_t vecs [4];

  initial begin
    int guard;
    rst = 1'b1;
    clear_bench();

    //          limit pe  blk err done res bursts
    vecs[0] = '{128,  8,  0,  0,  1,   8,  8};   // nominal full run
    vecs[1] = '{26,   0,  0,  1,  0,   0,  1};   // underrun in first WAIT
    vecs[2] = '{128,  8,  1,  0,  1,   8,  8};   // result backpressure
    vecs[3] = '{128,  3,  0,  1,  0,   3,  8};   // PE goes silent -> timeout

    for (int s = 0; s < 4; s++) run_scenario(vecs[s], 1'b1);

    // Reset in the middle of the third LOAD burst, then a clean rerun
    do_reset();
    data_limit = 128;
    pe_words   = 8;
    inst_en = 1;
    data_en = 1;
    start   = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!(bursts == 3 && run_len == 5) && guard < 2000) begin
      step();
      guard++;
    end
    check("mid_burst_reached", 64'(din_pe_v), 64'd1);
    rst = 1'b1;
    step();
    check_reset_outputs("mid_rst");
    clear_bench();
    rst = 1'b0;
    step();
    step();
    check("mid_rst_idle", 64'({busy, done, err}), 64'd0);
    run_scenario(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
